sdram_rr_arbiter: RTL and testbench

//  Shares one toggle-handshake SDRAM controller port (req/ack toggle, addr[24:1], rd, wrl/wrh, din/dout)

---
 rtl/sdram_arb_pkg.sv | 20 ++
 rtl/sdram_rr_arbiter_if.sv | 36 +++
 rtl/sdram_rr_arbiter_rr_pick.sv | 24 ++
 rtl/sdram_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_sdram_rr_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the round-robin SDRAM port arbiter.
package sdram_arb_pkg;

  localparam int unsigned NCLI_MAX = 8;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned BE_W     = 2;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Byte enables become write strobes {wrh,wrl} only for writes.
  function automatic logic [1:0] be_to_wr(input logic we, input logic [1:0] be);
    return we ? be : 2'b00;
  endfunction

endpackage

// File: rtl/sdram_rr_arbiter_if.sv
// Client-side level/ready bus plus toggle-handshake controller port.
interface sdram_rr_arbiter_if #(
  parameter int unsigned NCLI = 4,
  parameter int unsigned AW   = 24
);

  logic [NCLI-1:0]      cli_req;
  logic [NCLI-1:0]      cli_we;
  logic [2*NCLI-1:0]    cli_be;
  logic [NCLI*AW-1:0]   cli_addr;
  logic [NCLI*16-1:0]   cli_din;
  logic [NCLI-1:0]      cli_ready;
  logic [15:0]          cli_dout;

  logic                 sd_req;
  logic                 sd_ack;
  logic [AW-1:0]        sd_addr;
  logic                 sd_rd;
  logic                 sd_wrl;
  logic                 sd_wrh;
  logic [15:0]          sd_din;
  logic [15:0]          sd_dout;

  // Arbiter side.
  modport slave (
    input  cli_req, cli_we, cli_be, cli_addr, cli_din, sd_ack, sd_dout,
    output cli_ready, cli_dout, sd_req, sd_addr, sd_rd, sd_wrl, sd_wrh, sd_din
  );

  // Environment side: clients and controller.
  modport master (
    output cli_req, cli_we, cli_be, cli_addr, cli_din, sd_ack, sd_dout,
    input  cli_ready, cli_dout, sd_req, sd_addr, sd_rd, sd_wrl, sd_wrh, sd_din
  );

endinterface

// File: rtl/sdram_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first asserted request at or after base.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] base_i,
  output logic          valid_c_o,
  output logic [IW-1:0] idx_c_o
);

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    valid_c_o = 1'b0;
    idx_c_o   = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (req_i[(int'(base_i) + k) % int'(N)]) begin
        valid_c_o = 1'b1;
        idx_c_o   = IW'((int'(base_i) + k) % int'(N));
      end
    end
  end

endmodule

// File: rtl/sdram_rr_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake SDRAM port among NCLI clients.
module sdram_rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NCLI = 4,
  parameter int unsigned AW   = 24
) (
  input logic              clk,
  input logic              reset,
  sdram_rr_arbiter_if.slave bus
);

  localparam int unsigned IW = (NCLI > 1) ? $clog2(NCLI) : 1;

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic              sd_req_q, sd_req_d;
  logic [AW-1:0]     sd_addr_q, sd_addr_d;
  logic              sd_rd_q, sd_rd_d;
  logic              sd_wrl_q, sd_wrl_d;
  logic              sd_wrh_q, sd_wrh_d;
  logic [DATA_W-1:0] sd_din_q, sd_din_d;
  logic [NCLI-1:0]   cli_ready_q, cli_ready_d;
  logic [DATA_W-1:0] cli_dout_q, cli_dout_d;

  logic              pick_valid_c;
  logic [IW-1:0]     pick_idx_c;
  logic              sel_we_c;
  logic [BE_W-1:0]   sel_be_c;
  logic [AW-1:0]     sel_addr_c;
  logic [DATA_W-1:0] sel_din_c;

  rr_pick #(.N(NCLI), .IW(IW)) u_pick (
    .req_i     (bus.cli_req),
    .base_i    (rr_ptr_q),
    .valid_c_o (pick_valid_c),
    .idx_c_o   (pick_idx_c)
  );

  // Payload of the client the picker selected this cycle.
  assign sel_we_c   = bus.cli_we[pick_idx_c];
  assign sel_be_c   = bus.cli_be[32'(pick_idx_c) * BE_W +: BE_W];
  assign sel_addr_c = bus.cli_addr[32'(pick_idx_c) * AW +: AW];
  assign sel_din_c  = bus.cli_din[32'(pick_idx_c) * DATA_W +: DATA_W];

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SYNC;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      sd_req_q    <= 1'b0;
      sd_addr_q   <= '0;
      sd_rd_q     <= 1'b0;
      sd_wrl_q    <= 1'b0;
      sd_wrh_q    <= 1'b0;
      sd_din_q    <= '0;
      cli_ready_q <= '0;
      cli_dout_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      sd_req_q    <= sd_req_d;
      sd_addr_q   <= sd_addr_d;
      sd_rd_q     <= sd_rd_d;
      sd_wrl_q    <= sd_wrl_d;
      sd_wrh_q    <= sd_wrh_d;
      sd_din_q    <= sd_din_d;
      cli_ready_q <= cli_ready_d;
      cli_dout_q  <= cli_dout_d;
    end
  end

  // Next-state: sync to controller, grant, wait for ack, pulse ready.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    sd_req_d    = sd_req_q;
    sd_addr_d   = sd_addr_q;
    sd_rd_d     = sd_rd_q;
    sd_wrl_d    = sd_wrl_q;
    sd_wrh_d    = sd_wrh_q;
    sd_din_d    = sd_din_q;
    cli_ready_d = '0;
    cli_dout_d  = cli_dout_q;

    case (state_q)
      SYNC: begin
        // A stale access from before reset must land before anything new is issued.
        if (bus.sd_ack == sd_req_q) state_d = IDLE;
      end
      IDLE: begin
        if (pick_valid_c) begin
          grant_d = pick_idx_c;
          if (sel_we_c && (sel_be_c == 2'b00)) begin
            // Empty write: nothing to send downstream, just complete it.
            state_d = DONE;
          end else begin
            sd_addr_d              = sel_addr_c;
            sd_din_d               = sel_din_c;
            sd_rd_d                = ~sel_we_c;
            {sd_wrh_d, sd_wrl_d}   = be_to_wr(sel_we_c, sel_be_c);
            sd_req_d               = ~sd_req_q;
            state_d                = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.sd_ack == sd_req_q) begin
          if (sd_rd_q) cli_dout_d = bus.sd_dout;
          state_d = DONE;
        end
      end
      DONE: begin
        cli_ready_d[grant_q] = 1'b1;
        rr_ptr_d = (grant_q == IW'(NCLI - 1)) ? '0 : grant_q + IW'(1);
        state_d  = IDLE;
      end
      default: state_d = SYNC;
    endcase
  end

  assign bus.sd_req    = sd_req_q;
  assign bus.sd_addr   = sd_addr_q;
  assign bus.sd_rd     = sd_rd_q;
  assign bus.sd_wrl    = sd_wrl_q;
  assign bus.sd_wrh    = sd_wrh_q;
  assign bus.sd_din    = sd_din_q;
  assign bus.cli_ready = cli_ready_q;
  assign bus.cli_dout  = cli_dout_q;

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Directed bench for sdram_rr_arbiter with a small toggle-handshake controller model.
module tb_sdram_rr_arbiter;

  localparam int unsigned NCLI = 4;
  localparam int unsigned AW   = 24;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  sdram_rr_arbiter_if #(.NCLI(NCLI), .AW(AW)) bus();

  sdram_rr_arbiter #(.NCLI(NCLI), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Controller model: manual ack level, or auto-ack after ctl_delay cycles.
  logic        ctl_en    = 1'b0;
  logic        man_ack   = 1'b1;
  logic        ack_r     = 1'b1;
  int          ctl_delay = 3;
  logic [15:0] ctl_data  = 16'h0000;
  logic [15:0] dout_r    = 16'h0000;
  int          cnt       = 0;

  logic        exp_req   = 1'b0;
  int          exp_ptr   = 0;

  always @(posedge clk) begin
    if (!ctl_en) begin
      ack_r <= man_ack;
      cnt   <= 0;
    end else if (bus.sd_req != ack_r) begin
      if (cnt >= ctl_delay - 1) begin
        ack_r  <= bus.sd_req;
        dout_r <= ctl_data;
        cnt    <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  assign bus.sd_ack  = ack_r;
  assign bus.sd_dout = dout_r;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cli(input int i, input logic we, input logic [1:0] be,
                         input logic [AW-1:0] addr, input logic [15:0] din);
    bus.cli_we[i]              = we;
    bus.cli_be[i*2 +: 2]       = be;
    bus.cli_addr[i*AW +: AW]   = addr;
    bus.cli_din[i*16 +: 16]    = din;
  endtask

  task automatic test_reset();
    int n;
    bus.cli_req  = '0;
    bus.cli_we   = '0;
    bus.cli_be   = '0;
    bus.cli_addr = '0;
    bus.cli_din  = '0;
    ctl_en  = 1'b0;
    man_ack = 1'b1;
    reset   = 1'b1;
    tick();
    tick();
    checks++; if (bus.sd_req !== 1'b0) begin failures++; $display("FAIL rst_sd_req got=%0h exp=0", bus.sd_req); end
    checks++; if (bus.sd_rd !== 1'b0) begin failures++; $display("FAIL rst_sd_rd got=%0h exp=0", bus.sd_rd); end
    checks++; if ({bus.sd_wrh, bus.sd_wrl} !== 2'b00) begin failures++; $display("FAIL rst_sd_wr got=%0h exp=0", {bus.sd_wrh, bus.sd_wrl}); end
    checks++; if (bus.sd_addr !== 24'h0) begin failures++; $display("FAIL rst_sd_addr got=%0h exp=0", bus.sd_addr); end
    checks++; if (bus.sd_din !== 16'h0) begin failures++; $display("FAIL rst_sd_din got=%0h exp=0", bus.sd_din); end
    checks++; if (bus.cli_ready !== 4'h0) begin failures++; $display("FAIL rst_cli_ready got=%0h exp=0", bus.cli_ready); end
    checks++; if (bus.cli_dout !== 16'h0) begin failures++; $display("FAIL rst_cli_dout got=%0h exp=0", bus.cli_dout); end

    reset = 1'b0;
    set_cli(2, 1'b0, 2'b11, 24'h000222, 16'h0);
    bus.cli_req[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.sd_req !== 1'b0 || bus.cli_ready !== 4'h0) begin
        failures++; $display("FAIL sync_hold got sd_req=%0h ready=%0h exp 0/0", bus.sd_req, bus.cli_ready);
      end
    end
    man_ack = 1'b0;
    tick();
    tick();
    checks++; if (bus.sd_req !== 1'b0) begin failures++; $display("FAIL sync_exit_early got=%0h exp=0", bus.sd_req); end
    tick();
    exp_req = 1'b1;
    checks++; if (bus.sd_req !== exp_req) begin failures++; $display("FAIL sync_first_issue got=%0h exp=%0h", bus.sd_req, exp_req); end
    checks++; if (bus.sd_addr !== 24'h000222) begin failures++; $display("FAIL sync_addr got=%0h exp=222", bus.sd_addr); end
    ctl_delay = 3;
    ctl_data  = 16'h2222;
    ctl_en    = 1'b1;
    n = 0;
    while (bus.cli_ready === 4'h0 && n < 40) begin tick(); n++; end
    checks++; if (bus.cli_ready !== 4'b0100) begin failures++; $display("FAIL sync_ready got=%0h exp=4", bus.cli_ready); end
    checks++; if (bus.cli_dout !== 16'h2222) begin failures++; $display("FAIL sync_dout got=%0h exp=2222", bus.cli_dout); end
    bus.cli_req = '0;
    exp_ptr = 3;
    tick();
  endtask

  task automatic test_single_read();
    int n;
    int ack_t;
    logic req_stable;
    set_cli(1, 1'b0, 2'b11, 24'h012345, 16'h0);
    ctl_delay = 6;
    ctl_data  = 16'hBEEF;
    bus.cli_req[1] = 1'b1;
    tick();
    exp_req = ~exp_req;
    checks++; if (bus.sd_req !== exp_req) begin failures++; $display("FAIL rd_toggle got=%0h exp=%0h", bus.sd_req, exp_req); end
    checks++; if (bus.sd_rd !== 1'b1) begin failures++; $display("FAIL rd_sd_rd got=%0h exp=1", bus.sd_rd); end
    checks++; if ({bus.sd_wrh, bus.sd_wrl} !== 2'b00) begin failures++; $display("FAIL rd_sd_wr got=%0h exp=0", {bus.sd_wrh, bus.sd_wrl}); end
    checks++; if (bus.sd_addr !== 24'h012345) begin failures++; $display("FAIL rd_addr got=%0h exp=12345", bus.sd_addr); end
    n = 0;
    ack_t = -1;
    req_stable = 1'b1;
    while (bus.cli_ready === 4'h0 && n < 40) begin
      tick();
      n++;
      if (ack_t < 0 && bus.sd_ack === bus.sd_req) ack_t = n;
      if (bus.sd_req !== exp_req) req_stable = 1'b0;
    end
    checks++; if (bus.cli_ready !== 4'b0010) begin failures++; $display("FAIL rd_ready got=%0h exp=2", bus.cli_ready); end
    checks++; if (bus.cli_dout !== 16'hBEEF) begin failures++; $display("FAIL rd_dout got=%0h exp=beef", bus.cli_dout); end
    checks++; if (n - ack_t !== 2) begin failures++; $display("FAIL rd_ack_to_ready got=%0d exp=2", n - ack_t); end
    checks++; if (req_stable !== 1'b1) begin failures++; $display("FAIL rd_single_toggle got=%0h exp=1", req_stable); end
    bus.cli_req = '0;
    tick();
    checks++; if (bus.cli_ready !== 4'h0) begin failures++; $display("FAIL rd_ready_width got=%0h exp=0", bus.cli_ready); end
    exp_ptr = 2;
  endtask

  task automatic test_round_robin();
    int n;
    int idx;
    logic [3:0] exp_rdy;
    ctl_delay = 2;
    ctl_data  = 16'h0C0D;
    for (int i = 0; i < 4; i++) set_cli(i, 1'b0, 2'b11, AW'(24'h000100 + i), 16'h0);
    bus.cli_req = 4'hF;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (bus.cli_ready === 4'h0 && n < 40) begin tick(); n++; end
      idx = (exp_ptr + k) % 4;
      exp_rdy = 4'b0001 << idx;
      exp_req = ~exp_req;
      checks++; if (bus.cli_ready !== exp_rdy) begin failures++; $display("FAIL rr_order k=%0d got=%0h exp=%0h", k, bus.cli_ready, exp_rdy); end
      checks++; if (bus.sd_addr !== AW'(24'h000100 + idx)) begin failures++; $display("FAIL rr_addr k=%0d got=%0h exp=%0h", k, bus.sd_addr, 24'h000100 + idx); end
      if (k == 7) bus.cli_req = '0;
      tick();
    end
    checks++; if (bus.sd_req !== exp_req) begin failures++; $display("FAIL rr_toggles got=%0h exp=%0h", bus.sd_req, exp_req); end
    checks++; if (bus.cli_dout !== 16'h0C0D) begin failures++; $display("FAIL rr_dout got=%0h exp=c0d", bus.cli_dout); end
  endtask

  task automatic test_write();
    int n;
    ctl_delay = 3;
    ctl_data  = 16'hDEAD;
    set_cli(3, 1'b1, 2'b10, 24'h0ABCDE, 16'hA55A);
    bus.cli_req[3] = 1'b1;
    tick();
    exp_req = ~exp_req;
    checks++; if (bus.sd_req !== exp_req) begin failures++; $display("FAIL wr_toggle got=%0h exp=%0h", bus.sd_req, exp_req); end
    checks++; if (bus.sd_wrh !== 1'b1) begin failures++; $display("FAIL wr_wrh got=%0h exp=1", bus.sd_wrh); end
    checks++; if (bus.sd_wrl !== 1'b0) begin failures++; $display("FAIL wr_wrl got=%0h exp=0", bus.sd_wrl); end
    checks++; if (bus.sd_rd !== 1'b0) begin failures++; $display("FAIL wr_rd got=%0h exp=0", bus.sd_rd); end
    checks++; if (bus.sd_din !== 16'hA55A) begin failures++; $display("FAIL wr_din got=%0h exp=a55a", bus.sd_din); end
    checks++; if (bus.sd_addr !== 24'h0ABCDE) begin failures++; $display("FAIL wr_addr got=%0h exp=abcde", bus.sd_addr); end
    n = 0;
    while (bus.cli_ready === 4'h0 && n < 40) begin tick(); n++; end
    checks++; if (bus.cli_ready !== 4'b1000) begin failures++; $display("FAIL wr_ready got=%0h exp=8", bus.cli_ready); end
    checks++; if (bus.cli_dout !== 16'h0C0D) begin failures++; $display("FAIL wr_dout_held got=%0h exp=c0d", bus.cli_dout); end
    bus.cli_req = '0;
    tick();
    exp_ptr = 0;
  endtask

  task automatic test_zero_be();
    set_cli(0, 1'b1, 2'b00, 24'h000777, 16'h1234);
    bus.cli_req[0] = 1'b1;
    tick();
    checks++; if (bus.sd_req !== exp_req) begin failures++; $display("FAIL zbe_no_toggle got=%0h exp=%0h", bus.sd_req, exp_req); end
    checks++; if (bus.cli_ready !== 4'h0) begin failures++; $display("FAIL zbe_early_ready got=%0h exp=0", bus.cli_ready); end
    tick();
    checks++; if (bus.cli_ready !== 4'b0001) begin failures++; $display("FAIL zbe_ready got=%0h exp=1", bus.cli_ready); end
    checks++; if (bus.sd_req !== exp_req) begin failures++; $display("FAIL zbe_no_toggle2 got=%0h exp=%0h", bus.sd_req, exp_req); end
    bus.cli_req = '0;
    tick();
    checks++; if (bus.cli_ready !== 4'h0) begin failures++; $display("FAIL zbe_ready_width got=%0h exp=0", bus.cli_ready); end
    exp_ptr = 1;
  endtask

  task automatic test_reset_in_wait();
    int n;
    checks++; if (bus.sd_req !== exp_req) begin failures++; $display("FAIL riw_pre got=%0h exp=%0h", bus.sd_req, exp_req); end
    man_ack = exp_req;
    ctl_en  = 1'b0;
    tick();
    set_cli(2, 1'b0, 2'b11, 24'h000ABC, 16'h0);
    bus.cli_req[2] = 1'b1;
    tick();
    exp_req = ~exp_req;
    checks++; if (bus.sd_req !== exp_req) begin failures++; $display("FAIL riw_issue got=%0h exp=%0h", bus.sd_req, exp_req); end
    tick();
    tick();
    checks++; if (bus.cli_ready !== 4'h0) begin failures++; $display("FAIL riw_wait_ready got=%0h exp=0", bus.cli_ready); end
    reset = 1'b1;
    bus.cli_req = '0;
    tick();
    reset = 1'b0;
    set_cli(0, 1'b0, 2'b11, 24'h000321, 16'h0);
    bus.cli_req[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.sd_req !== 1'b0 || bus.cli_ready !== 4'h0) begin
        failures++; $display("FAIL riw_sync_hold got sd_req=%0h ready=%0h exp 0/0", bus.sd_req, bus.cli_ready);
      end
    end
    man_ack = 1'b0;
    tick();
    checks++; if (bus.sd_req !== 1'b0) begin failures++; $display("FAIL riw_ack_land got=%0h exp=0", bus.sd_req); end
    tick();
    checks++; if (bus.sd_req !== 1'b0) begin failures++; $display("FAIL riw_idle got=%0h exp=0", bus.sd_req); end
    tick();
    exp_req = 1'b1;
    checks++; if (bus.sd_req !== exp_req) begin failures++; $display("FAIL riw_next_issue got=%0h exp=1", bus.sd_req); end
    checks++; if (bus.sd_addr !== 24'h000321) begin failures++; $display("FAIL riw_next_addr got=%0h exp=321", bus.sd_addr); end
    ctl_delay = 2;
    ctl_data  = 16'h3333;
    ctl_en    = 1'b1;
    n = 0;
    while (bus.cli_ready === 4'h0 && n < 40) begin tick(); n++; end
    checks++; if (bus.cli_ready !== 4'b0001) begin failures++; $display("FAIL riw_next_ready got=%0h exp=1", bus.cli_ready); end
    checks++; if (bus.cli_dout !== 16'h3333) begin failures++; $display("FAIL riw_next_dout got=%0h exp=3333", bus.cli_dout); end
    bus.cli_req = '0;
    tick();
    checks++; if (bus.cli_ready !== 4'h0) begin failures++; $display("FAIL riw_ready_width got=%0h exp=0", bus.cli_ready); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_zero_be();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
